// File: rtl/k580vt57.sv
// Four-channel DMA controller in the style of the K580VT57/8257, one byte per 4-clk transfer (S1-S4).
// Optional ch2 autoload from ch3 is built when K580VT57_AUTOLOAD_EN is defined.
module k580vt57 (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    output logic [3:0]  dack,
    output logic        hrq,
    input  logic        hlda,
    output logic [15:0] oaddr,
    output logic        omemr_n,
    output logic        omemw_n,
    output logic        oior_n,
    output logic        oiow_n,
    output logic        tc,
    output logic        mark
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SREQ = 3'd1;
    localparam logic [2:0] ST_S1   = 3'd2;
    localparam logic [2:0] ST_S2   = 3'd3;
    localparam logic [2:0] ST_S3   = 3'd4;
    localparam logic [2:0] ST_S4   = 3'd5;

    localparam logic [1:0] XM_WRITE = 2'b01;
    localparam logic [1:0] XM_READ  = 2'b10;

    logic [15:0] ch_addr [4];
    logic [15:0] ch_cnt  [4];
    logic [7:0]  mode;
    logic [3:0]  tc_flag;
    logic        upd_flag;
    logic        byte_ff;
    logic        iwe_q;
    logic        ird_q;
    logic [2:0]  state;
    logic [1:0]  cur_ch;
    logic [1:0]  last_ch;
    logic        hrq_q;

    logic        wr_stb;
    logic        rd_stb;
    logic [3:0]  req;
    logic [3:0]  en_after;
    logic [3:0]  req_s4;
    logic [15:0] cnt_cur;
    logic [1:0]  xfer_mode;
    logic        is_tc;
    logic        autoload_hit;
    logic [1:0]  win;
    logic [1:0]  win_s4;
    logic        in_cycle;
    logic        strobe_win;

    // Rotating mode searches upward from the channel after 'last'; the last one
    // serviced is visited first and overwritten by every better candidate.
    function automatic logic [1:0] pick_ch(input logic [3:0] r, input logic [1:0] last,
                                           input logic rot);
        logic [1:0] c;
        pick_ch = 2'd0;
        if (rot) begin
            for (int i = 4; i >= 1; i--) begin
                c = last + i[1:0];
                if (r[c]) pick_ch = c;
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r[i]) pick_ch = i[1:0];
            end
        end
    endfunction

    assign wr_stb    = iwe_n & ~iwe_q & ~hlda;
    assign rd_stb    = ird_n & ~ird_q;
    assign req       = drq & mode[3:0];
    assign cnt_cur   = ch_cnt[cur_ch];
    assign xfer_mode = cnt_cur[15:14];
    assign is_tc     = (cnt_cur[13:0] == 14'd0);

`ifdef K580VT57_AUTOLOAD_EN
    assign autoload_hit = mode[7] && (cur_ch == 2'd2) && is_tc;
`else
    // Bit 7 is kept in the mode register but has no effect in this build.
    assign autoload_hit = 1'b0 && mode[7];
`endif

    assign en_after = (is_tc && mode[6] && !autoload_hit) ? (mode[3:0] & ~(4'b0001 << cur_ch))
                                                          : mode[3:0];
    assign req_s4   = drq & en_after;
    assign win      = pick_ch(req, last_ch, mode[4]);
    assign win_s4   = pick_ch(req_s4, cur_ch, mode[4]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                ch_addr[i] <= 16'h0000;
                ch_cnt[i]  <= 16'h0000;
            end
            mode     <= 8'h00;
            tc_flag  <= 4'h0;
            upd_flag <= 1'b0;
            byte_ff  <= 1'b0;
            iwe_q    <= 1'b1;
            ird_q    <= 1'b1;
            state    <= ST_IDLE;
            cur_ch   <= 2'd0;
            last_ch  <= 2'd3;
            hrq_q    <= 1'b0;
        end else begin
            iwe_q <= iwe_n;
            ird_q <= ird_n;

            if (wr_stb) begin
                if (!iaddr[3]) begin
                    case ({iaddr[0], byte_ff})
                        2'b00: ch_addr[iaddr[2:1]][7:0]  <= idata;
                        2'b01: ch_addr[iaddr[2:1]][15:8] <= idata;
                        2'b10: ch_cnt[iaddr[2:1]][7:0]   <= idata;
                        default: ch_cnt[iaddr[2:1]][15:8] <= idata;
                    endcase
                    byte_ff <= ~byte_ff;
                end else if (iaddr == 4'd8) begin
                    mode     <= idata;
                    byte_ff  <= 1'b0;
                    upd_flag <= 1'b0;
                end
            end

            if (rd_stb) begin
                if (!iaddr[3]) byte_ff <= ~byte_ff;
                else if (iaddr == 4'd8) tc_flag <= 4'h0;
            end

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_SREQ;
                        hrq_q <= 1'b1;
                    end
                end
                ST_SREQ: begin
                    if (!(|req)) begin
                        hrq_q <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hlda) begin
                        cur_ch <= win;
                        state  <= ST_S1;
                    end
                end
                ST_S1: state <= ST_S2;
                ST_S2: state <= ST_S3;
                ST_S3: state <= ST_S4;
                ST_S4: begin
                    ch_addr[cur_ch]      <= ch_addr[cur_ch] + 16'd1;
                    ch_cnt[cur_ch][13:0] <= cnt_cur[13:0] - 14'd1;
                    last_ch              <= cur_ch;
                    if (is_tc) begin
                        tc_flag[cur_ch] <= 1'b1;
                        if (mode[6]) mode[3:0] <= en_after;
                    end
`ifdef K580VT57_AUTOLOAD_EN
                    // Reload overrides the increment/decrement just scheduled for ch2.
                    if (autoload_hit) begin
                        ch_addr[2] <= ch_addr[3];
                        ch_cnt[2]  <= ch_cnt[3];
                        upd_flag   <= 1'b1;
                    end else if (cur_ch == 2'd2) begin
                        upd_flag <= 1'b0;
                    end
`endif
                    if (hlda && (|req_s4)) begin
                        cur_ch <= win_s4;
                        state  <= ST_S1;
                    end else begin
                        hrq_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    hrq_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_cycle   = (state == ST_S1) || (state == ST_S2) || (state == ST_S3);
    assign strobe_win = (state == ST_S2) || (state == ST_S3);

    assign hrq     = hrq_q;
    assign dack    = in_cycle ? (4'b0001 << cur_ch) : 4'b0000;
    assign oaddr   = (in_cycle || state == ST_S4) ? ch_addr[cur_ch] : 16'h0000;
    assign omemr_n = !(strobe_win && xfer_mode == XM_READ);
    assign oiow_n  = !(strobe_win && xfer_mode == XM_READ);
    assign oior_n  = !(strobe_win && xfer_mode == XM_WRITE);
    assign omemw_n = !((xfer_mode == XM_WRITE) &&
                       ((state == ST_S3) || (state == ST_S2 && mode[5])));
    assign tc      = strobe_win && is_tc;
    assign mark    = strobe_win && (cnt_cur[6:0] == 7'd0) && !is_tc;

    always_comb begin
        logic [15:0] sel;
        sel   = iaddr[0] ? ch_cnt[iaddr[2:1]] : ch_addr[iaddr[2:1]];
        odata = 8'h00;
        if (!iaddr[3]) odata = byte_ff ? sel[15:8] : sel[7:0];
        else if (iaddr == 4'd8) odata = {3'b000, upd_flag, tc_flag};
    end

endmodule

// File: tb/tb_k580vt57.sv
// Self-checking bench for k580vt57: register access table plus scoreboarded DMA transfer sequences.
module tb_k580vt57;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  iaddr;
    logic [7:0]  idata;
    logic [7:0]  odata;
    logic        iwe_n, ird_n;
    logic [3:0]  drq, dack;
    logic        hrq, hlda;
    logic [15:0] oaddr;
    logic        omemr_n, omemw_n, oior_n, oiow_n, tc, mark;

    k580vt57 dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .odata(odata),
        .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
        .oaddr(oaddr), .omemr_n(omemr_n), .omemw_n(omemw_n), .oior_n(oior_n),
        .oiow_n(oiow_n), .tc(tc), .mark(mark)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic [3:0]  s2;
        logic [3:0]  s3;
        logic        tc;
        logic        mark;
    } xfer_t;

    typedef struct {
        bit         rd;
        logic [3:0] a;
        logic [7:0] d;
    } cpu_vec_t;

    localparam logic [3:0] RD_S  = 4'b0110;  // {memr_n, memw_n, ior_n, iow_n}
    localparam logic [3:0] WR_S2 = 4'b1101;
    localparam logic [3:0] WR_S3 = 4'b1001;
    localparam logic [3:0] NONE  = 4'b1111;

    int    nvec = 0, nfail = 0;
    xfer_t exp_q[$];
    bit    mon_en = 1'b1, follow = 1'b1;
    wire [3:0] strb = {omemr_n, omemw_n, oior_n, oiow_n};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] dk, input logic [15:0] a, input logic [3:0] s2,
                        input logic [3:0] s3, input logic t, input logic m);
        xfer_t e;
        e.dack = dk; e.addr = a; e.s2 = s2; e.s3 = s3; e.tc = t; e.mark = m;
        exp_q.push_back(e);
    endtask

    // hlda follows hrq one half-cycle later
    initial forever begin
        @(negedge clk);
        if (follow) hlda = hrq;
    end

    // Capture each transfer S1..S4 and compare against the scoreboard.
    initial begin
        xfer_t o, e;
        logic t2, t3, m2, m3;
        forever begin
            @(negedge clk);
            if (mon_en && dack != 4'b0000) begin
                o.dack = dack; o.addr = oaddr;
                @(negedge clk); o.s2 = strb; t2 = tc; m2 = mark;
                @(negedge clk); o.s3 = strb; t3 = tc; m3 = mark;
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL xfer: unexpected dack %b addr %h", o.dack, o.addr);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", {o.dack, o.addr, o.s2, o.s3, t2, t3, m2, m3},
                          {e.dack, e.addr, e.s2, e.s3, e.tc, e.tc, e.mark, e.mark});
                end
            end
        end
    end

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); iaddr = a; idata = d; iwe_n = 1'b0;
        @(negedge clk); iwe_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_rd(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk); iaddr = a; ird_n = 1'b0;
        #1 check(name, odata, exp);
        @(negedge clk); ird_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic prog(input int ch, input logic [15:0] a, input logic [15:0] c);
        logic [3:0] ra, rc;
        ra = 4'(2 * ch);
        rc = 4'(2 * ch + 1);
        cpu_wr(ra, a[7:0]); cpu_wr(ra, a[15:8]);
        cpu_wr(rc, c[7:0]); cpu_wr(rc, c[15:8]);
    endtask

    task automatic do_reset();
        reset = 1'b1; drq = 4'b0000;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    // Drop drq once the last expected transfer has started.
    task automatic run_last(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (exp_q.size() == 1 && dack != 4'b0000) begin ok = 1'b1; break; end
        end
        if (!ok) begin nvec++; nfail++; $display("FAIL run_last: timeout, %0d pending", exp_q.size()); end
        drq = 4'b0000;
    endtask

    task automatic drain(input string name, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && hrq == 1'b0) begin ok = 1'b1; break; end
        end
        check(name, {ok, 8'(exp_q.size())}, {1'b1, 8'd0});
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail + 1);
        $fatal(1);
    end

    initial begin
        cpu_vec_t tbl[20];
        bit seen;
        tbl = '{'{0, 4'h8, 8'h00}, '{0, 4'h0, 8'h34}, '{0, 4'h0, 8'h12}, '{1, 4'h0, 8'h34},
                '{1, 4'h0, 8'h12}, '{0, 4'h1, 8'hFF}, '{0, 4'h1, 8'hFF}, '{1, 4'h1, 8'hFF},
                '{1, 4'h1, 8'hFF}, '{0, 4'h6, 8'hCD}, '{1, 4'h6, 8'h00}, '{0, 4'h6, 8'hAB},
                '{1, 4'h6, 8'h00}, '{1, 4'h6, 8'hAB}, '{0, 4'h0, 8'h55}, '{1, 4'h0, 8'h34},
                '{0, 4'h8, 8'h00}, '{1, 4'h0, 8'h34}, '{1, 4'h0, 8'h55}, '{1, 4'h8, 8'h00}};

        reset = 1'b1; iaddr = 4'h0; idata = 8'h00; iwe_n = 1'b1; ird_n = 1'b1;
        drq = 4'b0000; hlda = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out", {dack, hrq, strb, tc, mark, oaddr}, {4'b0000, 1'b0, NONE, 1'b0, 1'b0, 16'h0000});
        for (int i = 0; i <= 8; i++) begin
            iaddr = 4'(i);
            #1 check("reset_odata", odata, 8'h00);
        end

        // register access table
        foreach (tbl[i]) begin
            if (tbl[i].rd) cpu_rd("reg_rd", tbl[i].a, tbl[i].d);
            else cpu_wr(tbl[i].a, tbl[i].d);
        end

        // 80-transfer read burst on ch2
        do_reset();
        prog(2, 16'hC000, 16'h804F);
        cpu_wr(4'h8, 8'h04);
        for (int i = 0; i < 80; i++) push(4'b0100, 16'hC000 + 16'(i), RD_S, RD_S, i == 79, 1'b0);
        drq = 4'b0100;
        run_last(1000);
        drain("burst_drain", 100);
        cpu_rd("status_tc2", 4'h8, 8'h04);
        cpu_rd("status_clr", 4'h8, 8'h00);

        // fixed priority: ch0 before ch3
        do_reset();
        prog(0, 16'h0100, 16'h8000);
        prog(3, 16'h0300, 16'h8000);
        cpu_wr(4'h8, 8'h49);
        push(4'b0001, 16'h0100, RD_S, RD_S, 1'b1, 1'b0);
        push(4'b1000, 16'h0300, RD_S, RD_S, 1'b1, 1'b0);
        drq = 4'b1001;
        run_last(100);
        drain("fixed_drain", 50);

        // rotating priority: ch0/ch1 alternate
        do_reset();
        prog(0, 16'h1000, 16'h8001);
        prog(1, 16'h2000, 16'h8001);
        cpu_wr(4'h8, 8'h53);
        push(4'b0001, 16'h1000, RD_S, RD_S, 1'b0, 1'b0);
        push(4'b0010, 16'h2000, RD_S, RD_S, 1'b0, 1'b0);
        push(4'b0001, 16'h1001, RD_S, RD_S, 1'b1, 1'b0);
        push(4'b0010, 16'h2001, RD_S, RD_S, 1'b1, 1'b0);
        drq = 4'b0011;
        run_last(100);
        drain("rot_drain", 50);

        // write mode, normal then extended write; latency drq->hrq->dack
        for (int ext = 0; ext < 2; ext++) begin
            do_reset();
            prog(1, 16'h5555, 16'h4000);
            cpu_wr(4'h8, ext ? 8'h62 : 8'h42);
            push(4'b0010, 16'h5555, ext ? WR_S3 : WR_S2, WR_S3, 1'b1, 1'b0);
            @(negedge clk); drq = 4'b0010;
            @(negedge clk); check("drq_to_hrq", hrq, 1'b1);
            @(negedge clk); check("hlda_to_dack", dack, 4'b0010);
            drq = 4'b0000;
            drain("wr_drain", 20);
        end

        // TC stop on ch1 after 3 transfers
        do_reset();
        prog(1, 16'h0700, 16'h8002);
        cpu_wr(4'h8, 8'h42);
        for (int i = 0; i < 3; i++) push(4'b0010, 16'h0700 + 16'(i), RD_S, RD_S, i == 2, 1'b0);
        drq = 4'b0010;
        drain("tcstop_drain", 100);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (hrq) seen = 1'b1;
        end
        check("tcstop_no_hrq", seen, 1'b0);
        drq = 4'b0000;
        cpu_rd("tcstop_status", 4'h8, 8'h02);
        cpu_rd("tcstop_mode", 4'h8, 8'h00);

        // verify mode, mark when count is 0x80
        do_reset();
        prog(3, 16'h0000, 16'h0081);
        cpu_wr(4'h8, 8'h48);
        for (int i = 0; i < 130; i++) push(4'b1000, 16'(i), NONE, NONE, i == 129, i == 1);
        drq = 4'b1000;
        drain("mark_drain", 700);
        drq = 4'b0000;

`ifdef K580VT57_AUTOLOAD_EN
        do_reset();
        prog(2, 16'h1000, 16'h8001);
        prog(3, 16'h2000, 16'h8003);
        cpu_wr(4'h8, 8'h84);
        push(4'b0100, 16'h1000, RD_S, RD_S, 1'b0, 1'b0);
        push(4'b0100, 16'h1001, RD_S, RD_S, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push(4'b0100, 16'h2000 + 16'(i), RD_S, RD_S, i == 3, 1'b0);
        drq = 4'b0100;
        run_last(200);
        drain("auto_drain", 50);
        cpu_rd("auto_status", 4'h8, 8'h14);
`endif

        // reset during S2, then write ignored while hlda=1
        do_reset();
        prog(0, 16'h1234, 16'h8005);
        cpu_wr(4'h8, 8'h01);
        mon_en = 1'b0;
        drq = 4'b0001;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dack != 4'b0000) begin seen = 1'b1; break; end
        end
        check("rst_reach_s1", seen, 1'b1);
        @(negedge clk);
        check("rst_s2_memr", {omemr_n, oaddr}, {1'b0, 16'h1234});
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid", {dack, hrq, strb, tc, mark, oaddr}, {4'b0000, 1'b0, NONE, 1'b0, 1'b0, 16'h0000});
        reset = 1'b0; drq = 4'b0000;
        @(negedge clk);
        follow = 1'b0; hlda = 1'b1;
        cpu_wr(4'h0, 8'h77);
        hlda = 1'b0;
        cpu_rd("wr_ignored_lo", 4'h0, 8'h00);
        cpu_rd("wr_ignored_hi", 4'h0, 8'h00);
        follow = 1'b1; mon_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/k580vt57.md
# k580vt57

DMA controller modelled on the K580VT57 (8257): four prioritised channels, 16-bit address and 14-bit count registers per channel. It services DMA requests from display-side peripherals, such as the CRT controller's drq/dack pair, by taking the bus via hrq/hlda. For each transfer it drives the memory address plus paired memory/IO strobes, so the peripheral receives or supplies one byte per cycle. Sits between the CPU bus, the memory mux and the peripherals, all on the system clk.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- iaddr  in  4  register select (0-7 channel regs, 8 mode/status)
- idata  in  8  CPU write data
- odata  out  8  CPU read data (combinational mux of registers)
- iwe_n  in  1  CPU write strobe; a write is performed on its rising edge (sampled against a registered copy)
- ird_n  in  1  CPU read strobe; read side effects occur on its rising edge
- drq  in  4  per-channel DMA request, level
- dack  out  4  per-channel acknowledge, one-hot or zero
- hrq  out  1  bus hold request
- hlda  in  1  bus hold acknowledge
- oaddr  out  16  transfer address
- omemr_n, omemw_n, oior_n, oiow_n  out  1 each  active-low strobes
- tc  out  1  terminal count, asserted on the channel's last transfer
- mark  out  1  asserted when remaining count[6:0]==0

## Operation
- Registers per channel n:
  - address at 2n, 16-bit;
  - count at 2n+1, bits 13:0 = count, bits 15:14 = mode (00 verify, 01 write-to-memory, 10 read-from-memory, 11 illegal = treated as verify).
- Byte flip-flop: selects low then high byte and toggles on every channel-register access, read or write. It is cleared by reset and by any mode write.
- Mode register (addr 8, write):
  - bits 3:0 = channel enables
  - bit4 = rotating priority
  - bit5 = extended write
  - bit6 = TC stop
  - bit7 = autoload
- Status (addr 8, read): bits 3:0 = TC flags, bit4 = update flag, bits 7:5 = 0. The rising edge of ird_n on a status read clears bits 3:0.
- CPU register writes are ignored while hlda=1.
- A count of N gives N+1 transfers.
- State machine: IDLE, SREQ, S1, S2, S3, S4.
  - IDLE: if any (drq & enable), go to SREQ and set hrq=1.
  - SREQ:
    - if no enabled drq, clear hrq and go to IDLE;
    - otherwise, if hlda=1, latch the winning channel and go to S1.
  - Priority: fixed means ch0 highest. Rotating means the channel serviced last becomes lowest.
  - S1: oaddr = channel address; dack[ch]=1 for S1-S3.
  - S2: read mode drives omemr_n=0 and oiow_n=0 in S2-S3. Write mode drives oior_n=0 in S2-S3 and omemw_n=0 in S3 only, or S2-S3 with extended write. Verify mode drives no strobes.
  - tc = (count==0) and mark = (count[6:0]==0 && count!=0) are valid S2-S3.
  - S4: dack=0, strobes high. Address +1 (wraps 16'hFFFF→0). Count −1 (mod 2^14).
    - If this was TC: set TC flag[ch]; with TC stop, clear enable[ch].
    - Then re-arbitrate: if hlda=1 and any enabled drq, go to S1; else hrq=0 and go to IDLE.
- Simultaneous events:
  - A drq dropped during S1-S3 does not abort the cycle.
  - hlda dropped mid-cycle: the cycle completes, then the block goes to IDLE with hrq=0.
- Reset at any state: the next cycle is IDLE with all outputs at reset values.

## Timing
- Reset values: dack=0, hrq=0, all strobes=1, tc=0, mark=0, oaddr=0. All registers, mode, flags and the byte flip-flop are 0, so odata reads 0.
- Latencies:
  - drq to hrq: 1 clk.
  - hlda sampled high to dack: 1 clk (S1 registered).
- A transfer takes 4 clks (S1-S4). Back-to-back bursts run at 4 clks per byte.
- odata is combinational from iaddr and the current flip-flop state.

## Configuration
- K580VT57_AUTOLOAD_EN defined: with mode bit7=1, TC on ch2 in S4 reloads ch2 address/count/mode from ch3 and sets the update flag. Ch2 stays enabled regardless of TC stop.
- The update flag clears on the next ch2 transfer or on a mode write.
- Undefined: mode bit7 is stored but ignored; ch2 behaves like other channels; status bit4 reads 0.

## Test plan
- Program ch2 addr=0xC000, count=0x804F (read, 80 transfers), enable ch2; hold drq[2]=1 with hlda following hrq -> 80 cycles with oaddr 0xC000..0xC04F, omemr_n/oiow_n low in S2-S3, tc only on the 80th, status bit2=1, then a status read returns 0x04 and the next read returns 0x00.
- drq[0] and drq[3] raised together, fixed priority -> ch0 serviced first. With rotating priority and two back-to-back requests on ch0/ch1 -> alternating dack 1,2,1,2.
- Write mode, count=0x4000 (1 transfer), extended write off -> omemw_n low in S3 only, oior_n low in S2-S3. Extended write on -> omemw_n low in S2-S3.
- TC stop set, ch1 count 0x8002 -> after 3 transfers enable[1] clears; a further drq[1] produces no hrq.
- With K580VT57_AUTOLOAD_EN: ch2=0x1000/0x8001, ch3=0x2000/0x8003, autoload on -> after 2 transfers the next ones start at 0x2000, 4 transfers long; status bit4=1.
- Reset asserted during S2 -> next clk dack=0, strobes high, hrq=0; a CPU write while hlda=1 leaves registers unchanged.
